encoder_velocity_meter: RTL and testbench

//  Quadrature encoder front end for the motor speed loop. Synchronises raw A/B

---
 rtl/encoder_pkg.sv | 39 +++
 rtl/quad_decoder.sv | 98 +++++++++
 rtl/encoder_velocity_meter.sv | 105 ++++++++++
 tb/tb_encoder_velocity_meter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types, widths and step-classification helpers for encoder_velocity_meter.
package encoder_pkg;

  typedef enum logic {DEC_INIT = 1'b0, DEC_RUN = 1'b1} dec_state_t;

  localparam int VEL_W = 8;
  localparam int POS_W = 16;
  localparam int ACC_W = 16;

  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_UP   = 2'b01;
  localparam logic [1:0] STEP_DN   = 2'b10;
  localparam logic [1:0] STEP_BAD  = 2'b11;

  // Gray position 00->0, 01->1, 11->2, 10->3; a distance of 2 means both bits moved.
  function automatic logic [1:0] classify(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] prev_pos;
    logic [1:0] cur_pos;
    logic [1:0] diff;
    prev_pos = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    cur_pos  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
    diff     = cur_pos - prev_pos;
    case (diff)
      2'd0:    classify = STEP_NONE;
      2'd1:    classify = STEP_UP;
      2'd3:    classify = STEP_DN;
      default: classify = STEP_BAD;
    endcase
  endfunction

  function automatic logic [VEL_W-1:0] vel_mag(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W:0] ext;
    logic [ACC_W:0] mag;
    ext = {acc[ACC_W-1], acc};
    mag = acc[ACC_W-1] ? ((ACC_W+1)'(0) - ext) : ext;
    vel_mag = (mag > (ACC_W+1)'({VEL_W{1'b1}})) ? {VEL_W{1'b1}} : mag[VEL_W-1:0];
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Synchroniser, optional glitch filter (ENC_GLITCH_FILTER_EN) and 4x quadrature decode FSM.
// Emits single-cycle step_up / step_dn / illegal pulses.
module quad_decoder
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef ENC_GLITCH_FILTER_EN
  , parameter int FILT_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  output logic step_up,
  output logic step_dn,
  output logic illegal
);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             sync_ab;
  logic [1:0]             cur_ab;
  logic [1:0]             prev_ab;
  logic [1:0]             kind;
  dec_state_t             state;
  dec_state_t             state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
    end
  end

  assign sync_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef ENC_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_CYCLES + 1);
  logic [1:0]          filt_ab;
  logic [1:0][FCW-1:0] filt_cnt;

  // A channel follows its synced input only after FILT_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_ab  <= 2'b00;
      filt_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_ab[i] == filt_ab[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FCW'(FILT_CYCLES - 1)) begin
          filt_ab[i]  <= sync_ab[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FCW'(1);
        end
      end
    end
  end

  assign cur_ab = filt_ab;
`else
  assign cur_ab = sync_ab;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DEC_INIT;
      prev_ab <= 2'b00;
    end else begin
      state   <= state_next;
      prev_ab <= cur_ab;
    end
  end

  // INIT only latches the reference sample; RUN turns every transition into a pulse.
  always_comb begin
    state_next = state;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    illegal    = 1'b0;
    kind       = classify(prev_ab, cur_ab);
    case (state)
      DEC_INIT: state_next = DEC_RUN;
      DEC_RUN: begin
        step_up = (kind == STEP_UP);
        step_dn = (kind == STEP_DN);
        illegal = (kind == STEP_BAD);
      end
      default: state_next = DEC_INIT;
    endcase
  end

endmodule

// File: rtl/encoder_velocity_meter.sv
// Quadrature encoder velocity meter: window counter, saturating accumulator, position and outputs.
// Optional input glitch filter enabled by defining ENC_GLITCH_FILTER_EN.
module encoder_velocity_meter
  import encoder_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 50000,
  parameter int SYNC_STAGES   = 2
`ifdef ENC_GLITCH_FILTER_EN
  , parameter int FILT_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr_err,
  output logic [VEL_W-1:0] vel_out,
  output logic             vel_dir,
  output logic             vel_valid,
  output logic [POS_W-1:0] position,
  output logic             illegal_err
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                    step_up;
  logic                    step_dn;
  logic                    illegal;
  logic [CNT_W-1:0]        cnt;
  logic                    terminal;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] step_val;

  quad_decoder #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef ENC_GLITCH_FILTER_EN
    , .FILT_CYCLES(FILT_CYCLES)
`endif
  ) u_dec (
    .clk    (clk),
    .rst    (rst),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .step_up(step_up),
    .step_dn(step_dn),
    .illegal(illegal)
  );

  assign terminal = (cnt == CNT_W'(SAMPLE_CYCLES - 1));

  // Saturating accumulate, plus the value a fresh window starts from.
  always_comb begin
    acc_sum  = acc;
    step_val = '0;
    if (step_up) begin
      step_val = ACC_W'(1);
      acc_sum  = (acc == ACC_MAX) ? acc : acc + ACC_W'(1);
    end else if (step_dn) begin
      step_val = -ACC_W'(1);
      acc_sum  = (acc == ACC_MIN) ? acc : acc - ACC_W'(1);
    end else begin
      step_val = '0;
      acc_sum  = acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      vel_out     <= '0;
      vel_dir     <= 1'b0;
      vel_valid   <= 1'b0;
      position    <= '0;
      illegal_err <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (terminal) begin
        cnt       <= '0;
        vel_out   <= vel_mag(acc);
        vel_dir   <= (acc > ACC_W'(0));
        vel_valid <= 1'b1;
        acc       <= step_val;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= acc_sum;
      end
      if (step_up) begin
        position <= position + POS_W'(1);
      end else if (step_dn) begin
        position <= position - POS_W'(1);
      end
      // A coincident illegal event outranks the clear request.
      if (illegal) begin
        illegal_err <= 1'b1;
      end else if (clr_err) begin
        illegal_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder_velocity_meter.sv
// Scoreboard bench: two meters (100- and 400-cycle windows) share one randomized encoder stimulus.
module tb_encoder_velocity_meter;

  localparam int N0   = 100;
  localparam int N1   = 400;
  localparam int SYNC = 2;
`ifdef ENC_GLITCH_FILTER_EN
  localparam int FILT      = 4;
  localparam int LAT       = SYNC + FILT + 1;
  localparam int HOLD_MIN  = FILT;
  localparam int SAT_STEPS = 1500;
`else
  localparam int LAT       = SYNC + 1;
  localparam int HOLD_MIN  = 1;
  localparam int SAT_STEPS = 33000;
`endif

  typedef struct packed {
    int          at_edge;
    logic [7:0]  vel;
    logic        dir;
    logic [15:0] pos;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  vel_out_w   [2];
  logic        vel_dir_w   [2];
  logic        vel_valid_w [2];
  logic [15:0] pos_w       [2];
  logic        err_w       [2];

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   acc_m [2];
  logic [15:0] pos_m = 16'd0;
  logic [1:0]  ab_m = 2'b00;
  bit   wrap_done = 1'b0;

  encoder_velocity_meter #(.SAMPLE_CYCLES(N0), .SYNC_STAGES(SYNC)) dut0 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr_err(clr_err),
    .vel_out(vel_out_w[0]), .vel_dir(vel_dir_w[0]), .vel_valid(vel_valid_w[0]),
    .position(pos_w[0]), .illegal_err(err_w[0]));

  encoder_velocity_meter #(.SAMPLE_CYCLES(N1), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr_err(clr_err),
    .vel_out(vel_out_w[1]), .vel_dir(vel_dir_w[1]), .vel_valid(vel_valid_w[1]),
    .position(pos_w[1]), .illegal_err(err_w[1]));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edge_cnt = 0;
    else edge_cnt = edge_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, expected $finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int i, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d] at edge %0d: got %0d, expected %0d", name, i, edge_cnt, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int win_len(input int i);
    return (i == 0) ? N0 : N1;
  endfunction

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_at(input int idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int step_of(input logic [1:0] from, input logic [1:0] to);
    int d;
    d = (gidx(to) - gidx(from) + 4) % 4;
    if (d == 1) return 1;
    if (d == 3) return -1;
    return 0;
  endfunction

  function automatic logic [7:0] mag(input int a);
    int m;
    m = (a < 0) ? -a : a;
    return (m > 255) ? 8'd255 : 8'(m);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // A step whose effect edge closes a window belongs to the next window.
  task automatic model_advance(input int k, input int st);
    int   e;
    exp_t x;
    e = k + LAT;
    pos_m = pos_m + 16'(st);
    for (int i = 0; i < 2; i++) begin
      if (e % win_len(i) == 0) begin
        x.at_edge = e;
        x.vel     = mag(acc_m[i]);
        x.dir     = (acc_m[i] > 0);
        x.pos     = pos_m;
        if (i == 0) q0.push_back(x);
        else q1.push_back(x);
        acc_m[i] = st;
      end else begin
        acc_m[i] = clamp16(acc_m[i] + st);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick(input logic [1:0] ab, input logic clr, input bit track);
    int st;
    @(posedge clk);
    #1;
    {enc_a, enc_b} = ab;
    clr_err = clr;
    st = 0;
    if (track) begin
      st = step_of(ab_m, ab);
      ab_m = ab;
    end
    model_advance(edge_cnt, st);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick(ab_m, 1'b0, 1'b1);
  endtask

  // d = +1 forward, -1 reverse, 2 both channels at once
  task automatic move(input int d, input int hold);
    logic [1:0] nxt;
    if (d == 2) nxt = ~ab_m;
    else nxt = gray_at(gidx(ab_m) + d + 4);
    tick(nxt, 1'b0, 1'b1);
    idle(hold - 1);
  endtask

  task automatic flush_check();
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    #1;
    chk("pending_strobes", 0, q0.size(), 0);
    chk("pending_strobes", 1, q1.size(), 0);
  endtask

  task automatic do_reset();
    flush_check();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_vel_out", i, vel_out_w[i], 0);
      chk("rst_vel_dir", i, vel_dir_w[i], 0);
      chk("rst_vel_valid", i, vel_valid_w[i], 0);
      chk("rst_position", i, pos_w[i], 0);
      chk("rst_illegal_err", i, err_w[i], 0);
    end
    q0.delete();
    q1.delete();
    enc_a = 1'b0;
    enc_b = 1'b0;
    clr_err = 1'b0;
    ab_m = 2'b00;
    pos_m = 16'd0;
    acc_m[0] = 0;
    acc_m[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  task automatic check_strobe(input int i);
    exp_t x;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe[%0d] at edge %0d: got vel_valid=1, expected no strobe", i, edge_cnt);
    end else begin
      x = (i == 0) ? q0.pop_front() : q1.pop_front();
      chk("strobe_edge", i, edge_cnt, x.at_edge);
      chk("vel_out", i, vel_out_w[i], x.vel);
      chk("vel_dir", i, vel_dir_w[i], x.dir);
      chk("strobe_position", i, pos_w[i], x.pos);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (vel_valid_w[i]) check_strobe(i);
      end
    end
  end

  initial begin
    acc_m[0] = 0;
    acc_m[1] = 0;
    do_reset();

    // forward 40 steps, then reverse 40 steps, each from reset
    for (int s = 0; s < 40; s++) move(1, HOLD_MIN + 1);
    idle(30 + 4 * LAT);
    for (int i = 0; i < 2; i++) chk("fwd40_position", i, pos_w[i], 40);
    do_reset();
    for (int s = 0; s < 40; s++) move(-1, HOLD_MIN + 1);
    idle(30 + 4 * LAT);
    for (int i = 0; i < 2; i++) chk("rev40_position", i, pos_w[i], 16'hFFD8);
    do_reset();

    // a step whose effect lands exactly on the terminal cycle
    for (int s = 0; s < 5; s++) move(1, HOLD_MIN + 1);
    while (((edge_cnt + 1 + LAT) % N0) != 0) idle(1);
    move(1, HOLD_MIN + 1);
    for (int s = 0; s < 3; s++) move(1, HOLD_MIN + 1);
    idle(120);

    // sticky illegal_err, clear, and clear racing a new illegal event
    for (int i = 0; i < 2; i++) chk("err_before", i, err_w[i], 0);
    move(2, 1);
    idle(LAT);
    for (int i = 0; i < 2; i++) begin
      chk("err_set", i, err_w[i], 1);
      chk("illegal_position", i, pos_w[i], pos_m);
    end
    tick(ab_m, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 2; i++) chk("err_cleared", i, err_w[i], 0);
    idle(HOLD_MIN);
    move(2, 1);
    idle(LAT - 2);
    tick(ab_m, 1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 2; i++) chk("err_set_wins", i, err_w[i], 1);
    tick(ab_m, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 2; i++) chk("err_cleared2", i, err_w[i], 0);
    do_reset();

    // reset in the middle of a window with a partly filled accumulator
    for (int s = 0; s < 20; s++) move(1, HOLD_MIN + 1);
    while (edge_cnt < 50 - LAT) idle(1);
    do_reset();
    for (int s = 0; s < 7; s++) move(-1, HOLD_MIN + 1);
    idle(110);

    // randomized walk with illegal jumps and stray clears
    for (int n = 0; n < 300; n++) begin
      int r;
      int hold;
      r = $urandom_range(0, 9);
      hold = $urandom_range(HOLD_MIN, 8);
      if (r == 0) move(2, hold);
      else if (r <= 5) move(1, hold);
      else move(-1, hold);
      if ($urandom_range(0, 15) == 0) tick(ab_m, 1'b1, 1'b1);
    end
    idle(20);

`ifdef ENC_GLITCH_FILTER_EN
    tick(ab_m ^ 2'b10, 1'b0, 1'b0);
    tick(ab_m ^ 2'b10, 1'b0, 1'b0);
    tick(ab_m, 1'b0, 1'b1);
    idle(LAT + 2);
    for (int i = 0; i < 2; i++) chk("glitch_position", i, pos_w[i], pos_m);
`endif
    do_reset();

    // high-rate forward run: 3 steps per 4 cycles saturates vel_out, position wraps past 0x7FFF
    for (int s = 0; s < SAT_STEPS; s++) begin
      move(1, HOLD_MIN);
      if (s % 3 == 2) idle(1);
      if (!wrap_done && pos_m == 16'h8000) begin
        wrap_done = 1'b1;
        idle(LAT);
        for (int i = 0; i < 2; i++) chk("wrap_position", i, pos_w[i], 16'h8000);
      end
    end
    idle(10);

    flush_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
